uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage; the consumer of the frames produced by `uart_transmitter`. It oversamples the asynchronous line `RxD` at 16× the selected baud rate using its own `baud_controller` instance. It detects and qualifies the start bit, samples each bit at mid-period, checks odd parity and the stop bit, and presents the byte with a one-cycle valid strobe or an error strobe.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/baud_controller.sv | 31 +++
 rtl/uart_receiver.sv | 136 +++++++++++++
 tb/tb_uart_receiver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame constants and helpers
// used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_BITS  = 8;
    localparam int DIV_W      = 14;

    // Odd parity bit: data ones plus this bit always total an odd count.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // clk cycles per 16x tick for a 50 MHz clock: 300 ... 115200 baud.
    function automatic logic [DIV_W-1:0] baud_divisor(input logic [2:0] sel);
        case (sel)
            3'd0:    return 14'd10417;
            3'd1:    return 14'd2604;
            3'd2:    return 14'd651;
            3'd3:    return 14'd326;
            3'd4:    return 14'd163;
            3'd5:    return 14'd81;
            3'd6:    return 14'd54;
            default: return 14'd27;
        endcase
    endfunction

endpackage

// File: rtl/baud_controller.sv
// 16x-baud sample enable generator: a single-clk pulse every baud_divisor()
// cycles of the selected rate.
module baud_controller
    import uart_pkg::*;
(
    input  logic       reset,
    input  logic       clk,
    input  logic [2:0] i_baud_select,
    output logic       o_tick
);

    logic [DIV_W-1:0] r_count;
    logic             r_tick;

    // Down-counter so a rate change mid-count still reaches zero and reloads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (r_count == '0) begin
            r_count <= baud_divisor(i_baud_select) - 14'd1;
            r_tick  <= 1'b1;
        end else begin
            r_count <= r_count - 14'd1;
            r_tick  <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled start/data/odd-parity/stop framing with
// one-clk result strobes for a good byte, a parity error or a framing error.
module uart_receiver
    import uart_pkg::*;
(
    input  logic       reset,
    input  logic       clk,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR,
    output logic       Rx_BUSY
);

    localparam logic [3:0] SC_MID  = 4'(MID_SAMPLE);
    localparam logic [3:0] SC_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BI_LAST = 3'(DATA_BITS - 1);

    logic       w_tick;
    logic       r_rxd_meta;
    logic       r_rxd_s;
    rx_state_t  r_state;
    logic [3:0] r_sc;
    logic [2:0] r_bi;
    logic [7:0] r_shift;
    logic       r_parity;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_perror;
    logic       r_ferror;

    baud_controller u_baud (
        .reset         (reset),
        .clk           (clk),
        .i_baud_select (baud_select),
        .o_tick        (w_tick)
    );

    // Flops reset to 1 so the idle line is not mistaken for a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
        end else begin
            r_rxd_meta <= RxD;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sc     <= '0;
            r_bi     <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_data   <= 8'h00;
            r_valid  <= 1'b0;
            r_perror <= 1'b0;
            r_ferror <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            r_perror <= 1'b0;
            r_ferror <= 1'b0;
            if (!Rx_EN) begin
                r_state <= S_IDLE;
            end else if (w_tick) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_rxd_s) begin
                            r_state <= S_START;
                            r_sc    <= '0;
                        end
                    end
                    S_START: begin
                        if (r_sc == SC_MID) begin
                            r_sc <= '0;
                            r_bi <= '0;
                            r_state <= r_rxd_s ? S_IDLE : S_DATA;
                        end else begin
                            r_sc <= r_sc + 4'd1;
                        end
                    end
                    S_DATA: begin
                        r_sc <= r_sc + 4'd1;
                        if (r_sc == SC_LAST) begin
                            r_shift[r_bi] <= r_rxd_s;
                            r_bi          <= r_bi + 3'd1;
                            if (r_bi == BI_LAST)
                                r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_sc <= r_sc + 4'd1;
                        if (r_sc == SC_LAST) begin
                            r_parity <= r_rxd_s;
                            r_state  <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        r_sc <= r_sc + 4'd1;
                        if (r_sc == SC_LAST) begin
                            if (!r_rxd_s) begin
                                r_ferror <= 1'b1;
                                r_state  <= S_WAIT_IDLE;
                            end else if (r_parity != odd_parity(r_shift)) begin
                                r_perror <= 1'b1;
                                r_state  <= S_IDLE;
                            end else begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    S_WAIT_IDLE: begin
                        // A break or stuck-low line must not retrigger framing.
                        if (r_rxd_s)
                            r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign Rx_DATA   = r_data;
    assign Rx_VALID  = r_valid;
    assign Rx_PERROR = r_perror;
    assign Rx_FERROR = r_ferror;
    assign Rx_BUSY   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at the fastest rate (27 clk per 16x tick).
module tb_uart_receiver;

    localparam int TICK_CLKS = 27;
    localparam int BIT_CLKS  = TICK_CLKS * 16;

    logic       reset;
    logic       clk;
    logic [2:0] baud_select;
    logic       Rx_EN;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;
    logic       Rx_BUSY;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    int valid_cnt = 0;
    int perr_cnt  = 0;
    int ferr_cnt  = 0;
    int valid_cyc = 0;
    logic [7:0] vlog [32];

    int v0, p0, f0, t0, lat;

    uart_receiver dut (
        .reset       (reset),
        .clk         (clk),
        .baud_select (baud_select),
        .Rx_EN       (Rx_EN),
        .RxD         (RxD),
        .Rx_DATA     (Rx_DATA),
        .Rx_VALID    (Rx_VALID),
        .Rx_PERROR   (Rx_PERROR),
        .Rx_FERROR   (Rx_FERROR),
        .Rx_BUSY     (Rx_BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Every negedge a strobe is high counts once, so a stretched pulse over-counts.
    always @(negedge clk) begin
        if (Rx_VALID) begin
            vlog[valid_cnt % 32] = Rx_DATA;
            valid_cyc = cyc;
            valid_cnt++;
        end
        if (Rx_PERROR) perr_cnt++;
        if (Rx_FERROR) ferr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        v0 = valid_cnt;
        p0 = perr_cnt;
        f0 = ferr_cnt;
    endtask

    task automatic check_deltas(input string tag, input int dv, input int dp, input int df);
        check({tag, "_valid_cnt"}, 32'(valid_cnt - v0), 32'(dv));
        check({tag, "_perr_cnt"},  32'(perr_cnt - p0),  32'(dp));
        check({tag, "_ferr_cnt"},  32'(ferr_cnt - f0),  32'(df));
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        RxD = 1'b1;
        wait_clks(n);
    endtask

    // bits[0] goes on the line first.
    task automatic drive_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            RxD = bits[i];
            wait_clks(BIT_CLKS);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic p, input logic stop);
        drive_bits({stop, p, data, 1'b0}, 11);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset       = 1'b1;
        Rx_EN       = 1'b1;
        RxD         = 1'b1;
        baud_select = 3'd7;
        wait_clks(3);
        check("reset_data",   32'(Rx_DATA),   32'h00);
        check("reset_valid",  32'(Rx_VALID),  32'h0);
        check("reset_perror", 32'(Rx_PERROR), 32'h0);
        check("reset_ferror", 32'(Rx_FERROR), 32'h0);
        check("reset_busy",   32'(Rx_BUSY),   32'h0);
        reset = 1'b0;
        idle(2 * BIT_CLKS);

        // Good frame 0xA5 (four ones, p=1); stop mid-sample ~167 ticks after the edge.
        snap();
        t0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(BIT_CLKS);
        check_deltas("a5", 1, 0, 0);
        check("a5_data", 32'(Rx_DATA), 32'hA5);
        check("a5_busy", 32'(Rx_BUSY), 32'h0);
        lat = valid_cyc - t0;
        check($sformatf("a5_latency_clks_%0d", lat),
              32'((lat >= 167 * TICK_CLKS) && (lat <= 169 * TICK_CLKS + 4)), 32'h1);

        // 0x07 has three ones, so correct p=0; p=1 must give a parity error.
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        idle(BIT_CLKS);
        check_deltas("perr", 0, 1, 0);
        check("perr_data_kept", 32'(Rx_DATA), 32'hA5);

        // Stop bit low, line then held low for 40 ticks.
        snap();
        send_frame(8'h00, 1'b1, 1'b0);
        RxD = 1'b0;
        wait_clks(40 * TICK_CLKS);
        check_deltas("ferr", 0, 0, 1);
        check("ferr_busy_low_line", 32'(Rx_BUSY), 32'h1);
        RxD = 1'b1;
        wait_clks(3 * TICK_CLKS);
        check("ferr_busy_after_high", 32'(Rx_BUSY), 32'h0);
        idle(2 * BIT_CLKS);
        check_deltas("ferr_after", 0, 0, 1);
        check("ferr_data_kept", 32'(Rx_DATA), 32'hA5);

        // Four-tick low glitch: START entered, rejected at its mid-sample.
        snap();
        RxD = 1'b0;
        wait_clks(3 * TICK_CLKS);
        check("glitch_busy", 32'(Rx_BUSY), 32'h1);
        wait_clks(TICK_CLKS);
        RxD = 1'b1;
        wait_clks(8 * TICK_CLKS);
        check("glitch_idle", 32'(Rx_BUSY), 32'h0);
        idle(2 * BIT_CLKS);
        check_deltas("glitch", 0, 0, 0);

        // Back-to-back frames, one stop bit each.
        snap();
        send_frame(8'h3C, 1'b1, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b1);
        idle(BIT_CLKS);
        check_deltas("b2b", 2, 0, 0);
        check("b2b_first",  32'(vlog[v0 % 32]),       32'h3C);
        check("b2b_second", 32'(vlog[(v0 + 1) % 32]), 32'hC3);
        check("b2b_data",   32'(Rx_DATA),             32'hC3);

        // Rx_EN dropped a quarter of the way into the parity bit of 0x96.
        snap();
        drive_bits({1'b1, 1'b1, 8'h96, 1'b0}, 9);
        RxD = 1'b1;
        wait_clks(BIT_CLKS / 4);
        check("en_busy_before_drop", 32'(Rx_BUSY), 32'h1);
        Rx_EN = 1'b0;
        wait_clks(1);
        check("en_drop_busy", 32'(Rx_BUSY), 32'h0);
        check("en_drop_strobes", 32'({Rx_VALID, Rx_PERROR, Rx_FERROR}), 32'h0);
        wait_clks(BIT_CLKS);
        Rx_EN = 1'b1;
        idle(BIT_CLKS);
        check_deltas("en_drop", 0, 0, 0);
        check("en_drop_data_kept", 32'(Rx_DATA), 32'hC3);

        snap();
        send_frame(8'h5A, 1'b1, 1'b1);
        idle(BIT_CLKS);
        check_deltas("after_en", 1, 0, 0);
        check("after_en_data", 32'(Rx_DATA), 32'h5A);

        // Reset halfway through data bit 4 of 0xFF.
        snap();
        drive_bits({1'b1, 1'b1, 8'hFF, 1'b0}, 5);
        RxD = 1'b1;
        wait_clks(BIT_CLKS / 2);
        check("rst_busy_before", 32'(Rx_BUSY), 32'h1);
        reset = 1'b1;
        wait_clks(1);
        check("rst_mid_busy", 32'(Rx_BUSY), 32'h0);
        check("rst_mid_data", 32'(Rx_DATA), 32'h00);
        check("rst_mid_strobes", 32'({Rx_VALID, Rx_PERROR, Rx_FERROR}), 32'h0);
        wait_clks(2);
        reset = 1'b0;
        idle(2 * BIT_CLKS);
        check_deltas("rst_mid", 0, 0, 0);

        snap();
        send_frame(8'h5A, 1'b1, 1'b1);
        idle(BIT_CLKS);
        check_deltas("after_rst", 1, 0, 0);
        check("after_rst_data", 32'(Rx_DATA), 32'h5A);
        check("after_rst_busy", 32'(Rx_BUSY), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
